// File: rtl/sumador_pkg.sv
// Shared types and helpers for the bit-serial adder.
package sumador_pkg;

    // Control states: waiting for a request, adding bit by bit, result pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUMA = 2'd1,
        FIN  = 2'd2
    } estado_t;

    // Bit-counter width: enough to count 0..n-1, never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/medio_sumador.sv
// Half adder: two of these plus an OR make the full-adder bit slice.
module medio_sumador (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: rtl/sumador_serie.sv
// Bit-serial N-bit unsigned adder, LSB first, one bit per clock,
// with a start/busy/done handshake. {carry_out, suma} = a + b.
module sumador_serie
    import sumador_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] suma,
    output logic         carry_out,
    output logic         busy,
    output logic         done
);

    localparam int CW = cnt_width(N);

    estado_t         estado;
    estado_t         estado_next;
    logic [N-1:0]    ra;
    logic [N-1:0]    rb;
    logic [N-1:0]    rs;
    logic [N-1:0]    rs_next;
    logic            c;
    logic            c_next;
    logic [CW-1:0]   cnt;
    logic            ultimo;
    logic            s0;
    logic            c0;
    logic            s;
    logic            c1;

    // Full adder for the current bit slice, built from two half adders.
    medio_sumador u_ha0 (
        .x (ra[0]),
        .y (rb[0]),
        .s (s0),
        .c (c0)
    );

    medio_sumador u_ha1 (
        .x (s0),
        .y (c),
        .s (s),
        .c (c1)
    );

    assign c_next = c0 | c1;
    assign ultimo = (cnt == CW'(N - 1));

    // The new sum bit enters the result register from the MSB side, so after
    // N shifts bit 0 of the sum sits at rs[0]. A 1-bit result has nothing to shift.
    if (N == 1) begin : g_rs_1
        assign rs_next = s;
    end else begin : g_rs_n
        assign rs_next = {s, rs[N-1:1]};
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking (<=) so every register samples
        // pre-edge values; blocking here would create order-dependent races.
        if (rst) begin
            estado <= IDLE;
        end else begin
            estado <= estado_next;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; a missed
        // branch would otherwise infer a latch.
        estado_next = estado;
        busy        = 1'b0;
        done        = 1'b0;
        case (estado)
            IDLE: begin
                if (start) begin
                    estado_next = SUMA;
                end
            end
            SUMA: begin
                busy = 1'b1;
                if (ultimo) begin
                    estado_next = FIN;
                end
            end
            FIN: begin
                done        = 1'b1;
                estado_next = IDLE;
            end
            default: begin
                estado_next = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, serial add, and result publication on the last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            ra        <= '0;
            rb        <= '0;
            rs        <= '0;
            c         <= 1'b0;
            cnt       <= '0;
            suma      <= '0;
            carry_out <= 1'b0;
        end else begin
            case (estado)
                IDLE: begin
                    if (start) begin
                        ra  <= a;
                        rb  <= b;
                        c   <= 1'b0;
                        cnt <= '0;
                    end
                end
                SUMA: begin
                    c   <= c_next;
                    rs  <= rs_next;
                    ra  <= ra >> 1;
                    rb  <= rb >> 1;
                    cnt <= cnt + CW'(1);
                    // The previous result stays visible until this point.
                    if (ultimo) begin
                        suma      <= rs_next;
                        carry_out <= c_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sumador_serie.sv
// Self-checking bench for sumador_serie: an 8-bit instance for the main
// scenarios and a 1-bit instance as the inverse of the half subtractor.
module tb_sumador_serie;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic [7:0] suma8;
    logic       co8;
    logic       busy8;
    logic       done8;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic [0:0] suma1;
    logic       co1;
    logic       busy1;
    logic       done1;

    sumador_serie #(.N(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .start     (start8),
        .a         (a8),
        .b         (b8),
        .suma      (suma8),
        .carry_out (co8),
        .busy      (busy8),
        .done      (done8)
    );

    sumador_serie #(.N(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start1),
        .a         (a1),
        .b         (b1),
        .suma      (suma1),
        .carry_out (co1),
        .busy      (busy1),
        .done      (done1)
    );

    int         tests  = 0;
    int         fails  = 0;
    int         dones8 = 0;
    int         dones1 = 0;
    logic [8:0] exp_q8[$];
    logic [1:0] exp_q1[$];
    int         done_at[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for the 8-bit instance: every done pops one expected result.
    always @(negedge clk) begin
        if (done8) begin
            dones8++;
            check("done8_expected", 32'(exp_q8.size() != 0), 1);
            if (exp_q8.size() != 0) begin
                check("res8", {co8, suma8}, exp_q8.pop_front());
            end
        end
    end

    // Scoreboard for the 1-bit instance.
    always @(negedge clk) begin
        if (done1) begin
            dones1++;
            check("done1_expected", 32'(exp_q1.size() != 0), 1);
            if (exp_q1.size() != 0) begin
                check("res1", {co1, suma1}, exp_q1.pop_front());
            end
        end
    end

    // One-cycle request on the 8-bit instance, with latency and busy-length checks.
    task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic [8:0] exp,
                       input string tag);
        int cyc;
        int bcyc;
        a8     = x;
        b8     = y;
        start8 = 1'b1;
        exp_q8.push_back(exp);
        tick();
        start8 = 1'b0;
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        cyc    = 0;
        bcyc   = 0;
        while (!done8 && cyc < 50) begin
            if (busy8) bcyc++;
            tick();
            cyc++;
        end
        check({tag, "_latency"}, cyc, 8);
        check({tag, "_busy"}, bcyc, 8);
        tick();
        check({tag, "_done_low"}, done8, 0);
    endtask

    // One-cycle request on the 1-bit instance.
    task automatic op1(input logic x, input logic y, input logic [1:0] exp, input string tag);
        int cyc;
        int bcyc;
        a1     = x;
        b1     = y;
        start1 = 1'b1;
        exp_q1.push_back(exp);
        tick();
        start1 = 1'b0;
        cyc    = 0;
        bcyc   = 0;
        while (!done1 && cyc < 20) begin
            if (busy1) bcyc++;
            tick();
            cyc++;
        end
        check({tag, "_latency"}, cyc, 1);
        check({tag, "_busy"}, bcyc, 1);
        tick();
        check({tag, "_done_low"}, done1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         d;
        logic [7:0] x;
        logic [7:0] y;

        rst    = 1'b1;
        start8 = 1'b0;
        start1 = 1'b0;
        a8     = '0;
        b8     = '0;
        a1     = '0;
        b1     = '0;
        tick();
        tick();
        check("rst_suma", suma8, 0);
        check("rst_carry", co8, 0);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_busy1", busy1, 0);

        // Reset wins over a simultaneous start.
        start8 = 1'b1;
        a8     = 8'h12;
        b8     = 8'h34;
        tick();
        check("rst_vs_start_busy", busy8, 0);
        start8 = 1'b0;
        rst    = 1'b0;
        tick();
        check("rst_vs_start_idle", busy8, 0);

        op8(8'h3C, 8'h05, 9'h041, "basic");
        op8(8'hFF, 8'h01, 9'h100, "wrap_ff_01");
        op8(8'hFF, 8'hFF, 9'h1FE, "wrap_ff_ff");
        for (int i = 0; i < 4; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            op8(x, y, {1'b0, x} + {1'b0, y}, "rand");
        end

        // N=1: dif + B reconstructs A, carry equals the subtractor borrow.
        op1(1'b0, 1'b0, 2'b00, "hs_00");
        op1(1'b1, 1'b1, 2'b10, "hs_11");
        op1(1'b1, 1'b0, 2'b01, "hs_10");
        op1(1'b0, 1'b1, 2'b01, "hs_01");

        // Start while busy: the second request is lost.
        d      = dones8;
        a8     = 8'h10;
        b8     = 8'h20;
        start8 = 1'b1;
        exp_q8.push_back(9'h030);
        tick();
        start8 = 1'b0;
        tick();
        tick();
        a8     = 8'hAA;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (20) tick();
        check("busy_start_dones", dones8 - d, 1);
        check("busy_start_idle", busy8, 0);

        // Reset mid-operation: addition abandoned, result cleared, no done.
        a8     = 8'h55;
        b8     = 8'h11;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        check("mid_busy", busy8, 1);
        check("mid_prev_result", suma8, 8'h30);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", busy8, 0);
        check("midrst_suma", suma8, 0);
        check("midrst_carry", co8, 0);
        check("midrst_done", done8, 0);
        d = dones8;
        repeat (15) tick();
        check("midrst_no_done", dones8 - d, 0);
        op8(8'h01, 8'h02, 9'h003, "after_rst");

        // Back-to-back with start held high.
        d = dones8;
        repeat (3) exp_q8.push_back(9'h100);
        a8     = 8'h80;
        b8     = 8'h80;
        start8 = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done8) done_at.push_back(i);
        end
        start8 = 1'b0;
        repeat (12) tick();
        check("b2b_dones", dones8 - d, 3);
        check("b2b_first", (done_at.size() > 0) ? done_at[0] : -1, 8);
        if (done_at.size() == 3) begin
            check("b2b_period1", done_at[1] - done_at[0], 10);
            check("b2b_period2", done_at[2] - done_at[1], 10);
        end
        check("queues_empty", exp_q8.size() + exp_q1.size(), 0);
        check("total_dones1", dones1, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
